// File: rtl/jericalla_pkg.sv
// rtl/jericalla_pkg.sv - shared widths, instruction field positions and FSM states
package jericalla_pkg;

  localparam int INSTR_W = 17;
  localparam int DATA_W  = 32;
  localparam int FIELD_W = 4;

  // LSB positions of the instruction fields
  localparam int RAM_DIR = 13;
  localparam int OP      = 9;
  localparam int SRC1    = 5;
  localparam int SRC2    = 1;
  localparam int WEN     = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/secuenciador_jericalla_if.sv
// rtl/secuenciador_jericalla_if.sv - host load/run bus and datapath bus of the sequencer
interface secuenciador_jericalla_if #(
  parameter int AW = 4
);
  import jericalla_pkg::*;

  logic                 load_en;
  logic [AW-1:0]        load_dir;
  logic [INSTR_W-1:0]   load_instr;
  logic [AW:0]          prog_len;
  logic                 start;
  logic                 abort;
  logic                 stop_on_zf;
  logic [DATA_W-1:0]    datoOut_jericalla;
  logic                 zf_jericalla;
  logic [INSTR_W-1:0]   instruccion;
  logic                 busy;
  logic                 done;
  logic [DATA_W-1:0]    resultado;
  logic                 zf_final;
  logic [AW:0]          ejecutadas;
  logic [AW-1:0]        pc;

  modport master (
    input  load_en, load_dir, load_instr, prog_len, start, abort, stop_on_zf,
           datoOut_jericalla, zf_jericalla,
    output instruccion, busy, done, resultado, zf_final, ejecutadas, pc
  );

  modport slave (
    output load_en, load_dir, load_instr, prog_len, start, abort, stop_on_zf,
           datoOut_jericalla, zf_jericalla,
    input  instruccion, busy, done, resultado, zf_final, ejecutadas, pc
  );

endinterface

// File: rtl/secuenciador_jericalla_memoria_programa.sv
// rtl/secuenciador_jericalla_memoria_programa.sv - program buffer, sync write, async read
module memoria_programa
  import jericalla_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      wr_dir,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_dir,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_dir] <= wr_data;
    end
  end

  assign rd_data = mem[rd_dir];

endmodule

// File: rtl/secuenciador_jericalla.sv
// rtl/secuenciador_jericalla.sv - program sequencer issuing buffered instructions to the datapath
module secuenciador_jericalla
  import jericalla_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  secuenciador_jericalla_if.master  bus
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t             state;
  logic [AW:0]        len;
  logic               stop_lat;
  logic [INSTR_W-1:0] rd_data;
  logic [AW:0]        ejec_next;
  logic [AW:0]        len_next;

  // The buffer only accepts writes while idle, so a run never sees its program change.
  memoria_programa #(.DEPTH(DEPTH), .AW(AW)) u_memoria (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.load_en && (state == IDLE)),
    .wr_dir  (bus.load_dir),
    .wr_data (bus.load_instr),
    .rd_dir  (bus.pc),
    .rd_data (rd_data)
  );

  assign ejec_next = bus.ejecutadas + 1'b1;
  assign len_next  = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;

  // WEn is only ever passed through during ISSUE; SAMPLE holds the fields with the write disabled.
  always_comb begin
    bus.instruccion = '0;
    case (state)
      ISSUE:   bus.instruccion = rd_data;
      SAMPLE:  bus.instruccion = {rd_data[INSTR_W-1:WEN+1], 1'b0};
      default: bus.instruccion = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      len            <= '0;
      stop_lat       <= 1'b0;
      bus.pc         <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.resultado  <= '0;
      bus.zf_final   <= 1'b0;
      bus.ejecutadas <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len            <= len_next;
            stop_lat       <= bus.stop_on_zf;
            bus.ejecutadas <= '0;
            bus.pc         <= '0;
            if (len_next == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state    <= ISSUE;
              bus.busy <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            bus.resultado  <= bus.datoOut_jericalla;
            bus.zf_final   <= bus.zf_jericalla;
            bus.ejecutadas <= ejec_next;
            if ((stop_lat && bus.zf_jericalla) || (ejec_next == len)) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state  <= ISSUE;
              bus.pc <= bus.pc + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_jericalla.sv
// tb/tb_secuenciador_jericalla.sv - directed self-checking bench for secuenciador_jericalla
module tb_secuenciador_jericalla;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  secuenciador_jericalla_if #(.AW(4)) bus_if ();

  secuenciador_jericalla #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  // Datapath stand-in: result carries the instruction, op 4'hF yields a zero flag.
  assign bus_if.datoOut_jericalla = {bus_if.instruccion, 15'h1234};
  assign bus_if.zf_jericalla      = (bus_if.instruccion[12:9] == 4'hF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int dir, input logic [16:0] w);
    bus_if.load_en    = 1'b1;
    bus_if.load_dir   = 4'(dir);
    bus_if.load_instr = w;
    tick();
    bus_if.load_en    = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] len, input logic stop);
    bus_if.prog_len   = len;
    bus_if.stop_on_zf = stop;
    bus_if.start      = 1'b1;
    tick();
    bus_if.start      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_instr"}, 32'(bus_if.instruccion), 32'h0);
    check_val({tag, "_busy"},  32'(bus_if.busy),        32'h0);
    check_val({tag, "_done"},  32'(bus_if.done),        32'h0);
    check_val({tag, "_res"},   bus_if.resultado,        32'h0);
    check_val({tag, "_zf"},    32'(bus_if.zf_final),    32'h0);
    check_val({tag, "_ejec"},  32'(bus_if.ejecutadas),  32'h0);
    check_val({tag, "_pc"},    32'(bus_if.pc),          32'h0);
  endtask

  initial begin
    int          done_cyc;
    int          busy_cyc;
    logic [16:0] last_instr;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.load_en    = 1'b0;
    bus_if.load_dir   = '0;
    bus_if.load_instr = '0;
    bus_if.prog_len   = '0;
    bus_if.start      = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.stop_on_zf = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Two-instruction run
    load(0, 17'h0A5A5);
    load(1, 17'h1F0F1);
    start_run(5'd2, 1'b0);
    check_val("r1_c1_instr", 32'(bus_if.instruccion), 32'h0A5A5);
    check_val("r1_c1_busy",  32'(bus_if.busy), 32'h1);
    tick();
    check_val("r1_c2_instr", 32'(bus_if.instruccion), 32'h0A5A4);
    tick();
    check_val("r1_c3_instr", 32'(bus_if.instruccion), 32'h1F0F1);
    check_val("r1_c3_pc",    32'(bus_if.pc), 32'h1);
    tick();
    check_val("r1_c4_instr", 32'(bus_if.instruccion), 32'h1F0F0);
    check_val("r1_c4_done",  32'(bus_if.done), 32'h0);
    tick();
    check_val("r1_c5_done",  32'(bus_if.done), 32'h1);
    check_val("r1_c5_busy",  32'(bus_if.busy), 32'h0);
    check_val("r1_c5_instr", 32'(bus_if.instruccion), 32'h0);
    check_val("r1_ejec",     32'(bus_if.ejecutadas), 32'h2);
    check_val("r1_res",      bus_if.resultado, {17'h1F0F0, 15'h1234});
    tick();
    check_val("r1_c6_done",  32'(bus_if.done), 32'h0);

    // Stop on zero flag after the second instruction
    load(1, 17'h01E01);
    load(2, 17'h1F0F1);
    start_run(5'd3, 1'b1);
    tick();
    tick();
    check_val("r2_c3_instr", 32'(bus_if.instruccion), 32'h01E01);
    tick();
    tick();
    check_val("r2_done",  32'(bus_if.done), 32'h1);
    check_val("r2_ejec",  32'(bus_if.ejecutadas), 32'h2);
    check_val("r2_zf",    32'(bus_if.zf_final), 32'h1);
    check_val("r2_pc",    32'(bus_if.pc), 32'h1);
    check_val("r2_res",   bus_if.resultado, {17'h01E00, 15'h1234});
    tick();
    check_val("r2_idle_busy", 32'(bus_if.busy), 32'h0);

    // Zero-length run
    start_run(5'd0, 1'b0);
    check_val("r3_done",  32'(bus_if.done), 32'h1);
    check_val("r3_busy",  32'(bus_if.busy), 32'h0);
    check_val("r3_instr", 32'(bus_if.instruccion), 32'h0);
    check_val("r3_ejec",  32'(bus_if.ejecutadas), 32'h0);
    tick();
    check_val("r3_after_done", 32'(bus_if.done), 32'h0);

    // prog_len above DEPTH is capped
    for (int i = 0; i < 16; i++) begin
      load(i, {4'(i), 13'h0002});
    end
    start_run(5'd20, 1'b0);
    done_cyc   = 0;
    busy_cyc   = 0;
    last_instr = '0;
    for (int c = 1; c <= 100; c++) begin
      if (bus_if.done) begin
        done_cyc = c;
        break;
      end
      if (bus_if.busy) busy_cyc++;
      if (c == 31) last_instr = bus_if.instruccion;
      tick();
    end
    check_val("r4_done_cyc", 32'(done_cyc), 32'd33);
    check_val("r4_busy_cyc", 32'(busy_cyc), 32'd32);
    check_val("r4_pc",       32'(bus_if.pc), 32'd15);
    check_val("r4_ejec",     32'(bus_if.ejecutadas), 32'd16);
    check_val("r4_last",     32'(last_instr), 32'h1E002);
    tick();

    // Abort during the second ISSUE; loads during the run are dropped
    start_run(5'd4, 1'b0);
    bus_if.load_en    = 1'b1;
    bus_if.load_dir   = 4'd0;
    bus_if.load_instr = 17'h1FFFF;
    tick();
    tick();
    bus_if.load_en = 1'b0;
    check_val("r5_issue2", 32'(bus_if.instruccion), 32'h02002);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check_val("r5_busy",  32'(bus_if.busy), 32'h0);
    check_val("r5_instr", 32'(bus_if.instruccion), 32'h0);
    check_val("r5_done",  32'(bus_if.done), 32'h0);
    check_val("r5_ejec",  32'(bus_if.ejecutadas), 32'h1);
    tick();
    check_val("r5_done_late", 32'(bus_if.done), 32'h0);

    start_run(5'd1, 1'b0);
    check_val("r5_buf0_kept", 32'(bus_if.instruccion), 32'h00002);
    tick();
    tick();
    check_val("r5b_done", 32'(bus_if.done), 32'h1);
    tick();

    // Load and start on the same edge
    bus_if.load_en    = 1'b1;
    bus_if.load_dir   = 4'd0;
    bus_if.load_instr = 17'h0C0C1;
    start_run(5'd1, 1'b0);
    bus_if.load_en    = 1'b0;
    check_val("r6_instr", 32'(bus_if.instruccion), 32'h0C0C1);
    tick();
    tick();
    tick();

    // Reset in the middle of SAMPLE
    start_run(5'd2, 1'b0);
    tick();
    check_val("r7_sample_busy", 32'(bus_if.busy), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("r7_rst");
    start_run(5'd1, 1'b0);
    check_val("r7_instr", 32'(bus_if.instruccion), 32'h0);
    check_val("r7_busy",  32'(bus_if.busy), 32'h1);
    tick();
    tick();
    check_val("r7_done",  32'(bus_if.done), 32'h1);
    check_val("r7_ejec",  32'(bus_if.ejecutadas), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/secuenciador_jericalla.md
Name: secuenciador_jericalla

Overview:
Program sequencer for the single-cycle register/ALU/RAM datapath. It holds a small program buffer of 17-bit datapath instructions, issues them one at a time on start, and drives the datapath instruction bus. After each instruction it samples the datapath's 32-bit result and zero flag. It can stop early on a zero result and reports busy/done status.

Parameters:
DEPTH, 16, number of program-buffer entries (power of two)
AW, 4, log2(DEPTH); program-buffer address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
load_en  input  1  write load_instr into buffer[load_dir] (honoured only when idle)
load_dir  input  AW  program-buffer write address
load_instr  input  17  instruction word: [16:13] RAM addr, [12:9] ALU op, [8:5] src1, [4:1] src2, [0] WEn
prog_len  input  AW+1  instructions to run, sampled on start
start  input  1  one-cycle run request
abort  input  1  terminate the current run
stop_on_zf  input  1  sampled on start; end the run on the first zero result
datoOut_jericalla  input  32  datapath RAM output
zf_jericalla  input  1  datapath ALU zero flag
instruccion  output  17  instruction bus to the datapath
busy  output  1  run in progress
done  output  1  one-cycle pulse at normal or zf-stop completion
resultado  output  32  last sampled datapath output
zf_final  output  1  last sampled zero flag
ejecutadas  output  AW+1  instructions completed in the current/last run
pc  output  AW  index of the instruction being issued

Behaviour:
- Reset (rst_n=0 at a clock edge) clears every output, all internal registers and all buffer entries to 0; FSM goes to IDLE. A reset mid-run drops busy and the run on the same edge, with no done pulse.
- States: IDLE, ISSUE, SAMPLE, DONE.
- IDLE: instruccion=0 (WEn=0) and busy=0.
  - load_en writes the buffer on the edge.
  - On start: latch len=min(prog_len,DEPTH) and stop_on_zf, clear ejecutadas and pc.
  - If len=0, go to DONE; otherwise go to ISSUE.
- ISSUE (1 cycle): instruccion=buffer[pc], with WEn exactly as stored. This is the only cycle in which WEn can be 1. Next state is SAMPLE.
- SAMPLE (1 cycle): instruccion holds buffer[pc] with bit0 forced to 0.
  - At the end of the cycle: resultado<=datoOut_jericalla, zf_final<=zf_jericalla, ejecutadas<=ejecutadas+1.
  - If the latched stop flag=1 and zf_jericalla=1, or ejecutadas+1=len: go to DONE.
  - Otherwise pc<=pc+1 and go to ISSUE.
- DONE (1 cycle): done=1, busy=0, instruccion=0; then IDLE. resultado, zf_final and ejecutadas hold until the next start.
- busy=1 in ISSUE and SAMPLE only. Each instruction takes 2 cycles, so a run of N instructions goes from the start edge to the done pulse in 2N+1 cycles.
- pc wraps never: len is capped at DEPTH, so pc is at most DEPTH-1.
- abort in ISSUE or SAMPLE: next state IDLE and instruccion=0, with no done pulse and no sample on that edge. ejecutadas keeps the count of completed instructions. abort in IDLE or DONE is ignored.
- start while busy or in DONE: ignored.
- load_en while not IDLE: ignored, buffer unchanged.
- start and load_en on the same IDLE edge: the write completes. The first ISSUE reads the updated buffer.
- start and abort on the same IDLE edge: start wins.

Decomposition:
- Shared package (jericalla_pkg):
  - field-position constants for the 17-bit instruction (RAM_DIR, OP, SRC1, SRC2, WEN)
  - INSTR_W=17 and DATA_W=32
  - enum for the FSM states
- One natural sub-module: memoria_programa.
  - DEPTH x 17 register file, one synchronous write port, one asynchronous read port, synchronous clear on rst_n.
- FSM, counters and sample registers stay in the top module.

Test Plan:
- Load buffer[0]=17'h0A5A5, buffer[1]=17'h1F0F1; prog_len=2; start -> instruccion=0A5A5 in cycle 1, then 0A5A4, then 1F0F1, then 1F0F0. The done pulse is 5 cycles after start, with ejecutadas=2.
- Run of 3 with stop_on_zf=1, and the datapath model returns zf=1 on the 2nd SAMPLE -> done after the 2nd instruction, ejecutadas=2, zf_final=1. Instruction 3 is never issued.
- prog_len=0, start -> done one cycle later, busy never 1, ejecutadas=0, instruccion stays 0.
- prog_len=20 with DEPTH=16 -> exactly 16 instructions issued, pc reaches 15, done after 33 cycles.
- Abort during the 2nd ISSUE of a 4-instruction run -> next cycle busy=0, instruccion=0, no done, ejecutadas=1. load_en during the run leaves the buffer unchanged (read back by a subsequent run).
- rst_n=0 mid-SAMPLE -> the next cycle has all outputs 0 and state IDLE. A following run with prog_len=1 issues 17'h00000, since the buffer was cleared.
